// File: rtl/user_code_loader_mem_if.sv
// Loader/fetch bus of the runtime-loadable instruction store.
// Host side drives bytes and load control; CPU side drives fetch_addr.
interface user_code_loader_mem_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 5
);
    logic              load_start;
    logic              load_end;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              code_ready;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;
    logic [ADDR_W-1:0] fetch_addr;
    logic [WORD_W-1:0] fetch_data;

    modport master (
        output load_start, load_end, in_byte, in_valid, fetch_addr,
        input  in_ready, code_ready, load_err, words_loaded, fetch_data
    );

    modport slave (
        input  load_start, load_end, in_byte, in_valid, fetch_addr,
        output in_ready, code_ready, load_err, words_loaded, fetch_data
    );
endinterface

// File: rtl/user_code_loader_mem.sv
// Runtime-loadable instruction store: packs a byte stream into 16-bit words
// and serves registered fetches, holding the CPU off while a load runs.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   load_start/load_end/in_byte/in_valid/in_ready  host byte link
//   code_ready/load_err/words_loaded               load status
//   fetch_addr/fetch_data                          CPU fetch (1-cycle latency)
module user_code_loader_mem #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    user_code_loader_mem_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic [WORD_W-1:0] fetch_q;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic              full;

    assign full = (ptr_q == FULL);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        err_d   = err_q;
        we      = 1'b0;
        wdata   = '0;
        // Image becomes visible one cycle after the FSM is back in IDLE.
        rdy_d   = (state_q == IDLE);
        case (state_q)
            IDLE: ;
            LOAD_HI: begin
                if (bus.load_end) begin
                    state_d = IDLE;
                end else if (full) begin
                    state_d = IDLE;
                    if (bus.in_valid) err_d = 1'b1;
                end else if (bus.in_valid) begin
                    hi_d    = bus.in_byte;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                // Early end with a lone high byte: pad low byte, flag it.
                if (bus.load_end) begin
                    we      = 1'b1;
                    wdata   = {hi_q, 8'h00};
                    ptr_d   = ptr_q + 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    we      = 1'b1;
                    wdata   = {hi_q, bus.in_byte};
                    ptr_d   = ptr_q + 1'b1;
                    state_d = LOAD_HI;
                end
            end
            default: state_d = IDLE;
        endcase
        // Restart overrides everything, including a pending word write.
        if (bus.load_start) begin
            state_d = LOAD_HI;
            ptr_d   = '0;
            err_d   = 1'b0;
            we      = 1'b0;
            rdy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[ptr_q[ADDR_W-1:0]] <= wdata;
        end
    end

    // Fetch is gated by code_ready, so it never overlaps a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_q <= '0;
        else        fetch_q <= rdy_q ? mem_q[bus.fetch_addr] : '0;
    end

    assign bus.in_ready     = ((state_q == LOAD_HI) && !full)
                            || (state_q == LOAD_LO);
    assign bus.code_ready   = rdy_q;
    assign bus.load_err     = err_q;
    assign bus.words_loaded = ptr_q;
    assign bus.fetch_data   = fetch_q;
endmodule

// File: tb/tb_user_code_loader_mem.sv
// Directed bench for user_code_loader_mem.
// Linear stimulus, immediate-assertion checks, one summary line.
module tb_user_code_loader_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;

    user_code_loader_mem_if #(.WORD_W(16), .ADDR_W(5)) bus ();

    user_code_loader_mem #(.WORD_W(16), .DEPTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.load_end = 1'b1;
        step();
        bus.load_end = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [4:0] a,
                         input logic [15:0] exp);
        bus.fetch_addr = a;
        step();
        chk(tag, 32'(bus.fetch_data), 32'(exp));
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_end   = 1'b0;
        bus.in_byte    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.fetch_addr = 5'd0;
        #12 rst_n = 1'b1;
        step();

        // Reset state and blank memory
        chk("rst_code_ready", 32'(bus.code_ready), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_load_err", 32'(bus.load_err), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        for (int a = 0; a < 32; a++) fetch("rst_fetch", 5'(a), 16'h0000);

        // Short program
        pulse_start();
        chk("p1_code_ready_low", 32'(bus.code_ready), 32'd0);
        chk("p1_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'h80); send(8'h00); send(8'h84);
        send(8'h01); send(8'h11); send(8'h02);
        pulse_end();
        chk("p1_code_ready_still_low", 32'(bus.code_ready), 32'd0);
        step();
        chk("p1_code_ready", 32'(bus.code_ready), 32'd1);
        chk("p1_words", 32'(bus.words_loaded), 32'd3);
        chk("p1_err", 32'(bus.load_err), 32'd0);
        fetch("p1_w0", 5'd0, 16'h8000);
        fetch("p1_w1", 5'd1, 16'h8401);
        fetch("p1_w2", 5'd2, 16'h1102);

        // Fill all 32 words, then one extra byte while full
        pulse_start();
        chk("p2_words_cleared", 32'(bus.words_loaded), 32'd0);
        for (int i = 0; i < 64; i++) send(8'(i * 3 + 7));
        chk("p2_words", 32'(bus.words_loaded), 32'd32);
        chk("p2_in_ready_full", 32'(bus.in_ready), 32'd0);
        send(8'hEE);
        chk("p2_err", 32'(bus.load_err), 32'd1);
        step();
        chk("p2_code_ready", 32'(bus.code_ready), 32'd1);
        chk("p2_words_hold", 32'(bus.words_loaded), 32'd32);
        fetch("p2_w0", 5'd0, 16'h070A);
        fetch("p2_w31", 5'd31, 16'hC1C4);

        // Odd byte count: padded last word, error flagged
        pulse_start();
        chk("p3_err_cleared", 32'(bus.load_err), 32'd0);
        send(8'hAA); send(8'hBB); send(8'hCC);
        pulse_end();
        step();
        chk("p3_words", 32'(bus.words_loaded), 32'd2);
        chk("p3_err", 32'(bus.load_err), 32'd1);
        fetch("p3_w0", 5'd0, 16'hAABB);
        fetch("p3_w1", 5'd1, 16'hCC00);
        fetch("p3_w2_kept", 5'd2, 16'h1316);

        // Restart mid-load discards the pending high byte
        pulse_start();
        send(8'h56); send(8'h78); send(8'h9A);
        chk("p4_words_mid", 32'(bus.words_loaded), 32'd1);
        pulse_start();
        chk("p4_words_restart", 32'(bus.words_loaded), 32'd0);
        send(8'h12); send(8'h34);
        pulse_end();
        step();
        chk("p4_words", 32'(bus.words_loaded), 32'd1);
        chk("p4_err", 32'(bus.load_err), 32'd0);
        fetch("p4_w0", 5'd0, 16'h1234);
        fetch("p4_w1_kept", 5'd1, 16'hCC00);

        // load_end while idle is ignored
        pulse_end();
        chk("p5_idle_end_words", 32'(bus.words_loaded), 32'd1);
        chk("p5_idle_end_ready", 32'(bus.code_ready), 32'd1);

        // Asynchronous reset in the middle of a load
        pulse_start();
        send(8'hAB); send(8'hCD); send(8'hEF);
        chk("p6_loading", 32'(bus.code_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("p6_rst_code_ready", 32'(bus.code_ready), 32'd1);
        chk("p6_rst_words", 32'(bus.words_loaded), 32'd0);
        chk("p6_rst_err", 32'(bus.load_err), 32'd0);
        chk("p6_rst_fetch", 32'(bus.fetch_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        fetch("p6_w0", 5'd0, 16'h0000);
        fetch("p6_w1", 5'd1, 16'h0000);
        fetch("p6_w31", 5'd31, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
